// File: rtl/oam_dma_engine.sv
// oam_dma_engine
//   OAM DMA controller behind the FF46 register. A start strobe copies
//   OAM_BYTES bytes from {src,8'h00} into OAM at FE00 using a dedicated bus
//   master port. Each byte takes one M-cycle (CYCLES_PER_BYTE clocks):
//   ph0 read request, ph1 capture read data, ph2 OAM write.
//   A setup M-cycle (START) with no bus activity comes before the first byte.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   dma_start     one-clock strobe: FF46 written (restarts any copy in flight)
//   dma_src       source high byte, sampled with dma_start
//   mem_address   master address (0 when the bus is idle)
//   mem_re/we     read / write requests (never both high)
//   mem_rdata     read data, valid the clock after mem_re
//   mem_wdata     write data, valid while mem_we
//   busy          copy in progress
//   cpu_lock      CPU restricted to HRAM while busy (OAM_DMA_CPU_LOCK_EN)
//   done          one-clock pulse after the last OAM byte is written
//
// Configuration macro: OAM_DMA_CPU_LOCK_EN
//   defined   : cpu_lock is registered alongside busy and equals it
//   undefined : cpu_lock tied to 0
module oam_dma_engine #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int OAM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_src,
    output logic [15:0] mem_address,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        cpu_lock,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    localparam logic [3:0] PH_LAST  = 4'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);

    state_t     state, state_n;
    logic [3:0] ph, ph_n;
    logic [7:0] idx, idx_n;
    logic [7:0] src_q, src_n;
    logic [7:0] data_q;
    logic       fin;
    logic       re_n, we_n;

    // Next-state view; the outputs are registered from it so they line up
    // with the phase they describe instead of lagging by a clock.
    always_comb begin
        state_n = state;
        ph_n    = ph;
        idx_n   = idx;
        src_n   = src_q;
        fin     = 1'b0;
        if (dma_start) begin
            // A restart always wins, including on the final phase of a copy.
            state_n = START;
            ph_n    = 4'd0;
            idx_n   = 8'd0;
            // Echo RAM E000..FFFF folds down onto C000..DFFF.
            src_n   = (dma_src >= 8'hE0) ? (dma_src - 8'h20) : dma_src;
        end else begin
            case (state)
                START: begin
                    if (ph == PH_LAST) begin
                        state_n = XFER;
                        ph_n    = 4'd0;
                    end else begin
                        ph_n = ph + 4'd1;
                    end
                end
                XFER: begin
                    if (ph == PH_LAST) begin
                        ph_n = 4'd0;
                        if (idx == IDX_LAST) begin
                            state_n = IDLE;
                            idx_n   = 8'd0;
                            fin     = 1'b1;
                        end else begin
                            idx_n = idx + 8'd1;
                        end
                    end else begin
                        ph_n = ph + 4'd1;
                    end
                end
                default: ;
            endcase
        end
        re_n = (state_n == XFER) && (ph_n == 4'd0);
        we_n = (state_n == XFER) && (ph_n == 4'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ph          <= 4'd0;
            idx         <= 8'd0;
            src_q       <= 8'd0;
            data_q      <= 8'd0;
            mem_address <= 16'h0000;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state  <= state_n;
            ph     <= ph_n;
            idx    <= idx_n;
            src_q  <= src_n;
            // we_n is only true when leaving ph1 of a live copy, i.e. the
            // clock in which mem_rdata answers the ph0 read.
            if (we_n)
                data_q <= mem_rdata;
            mem_re      <= re_n;
            mem_we      <= we_n;
            mem_wdata   <= we_n ? mem_rdata : 8'd0;
            mem_address <= re_n ? {src_n, idx_n} :
                           we_n ? {8'hFE, idx_n} : 16'h0000;
            busy        <= (state_n != IDLE);
            done        <= fin;
        end
    end

`ifdef OAM_DMA_CPU_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst)
            cpu_lock <= 1'b0;
        else
            cpu_lock <= (state_n != IDLE);
    end
`else
    assign cpu_lock = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_engine.sv
// Testbench for oam_dma_engine: a 64 KiB byte memory model answers the DMA
// master port; expected timing and contents are derived from the copy rules
// (setup M-cycle, one M-cycle per byte, echo remap, restart, reset).
module tb_oam_dma_engine;
    localparam int CPB   = 4;
    localparam int NB    = 160;
    localparam int LAT   = CPB * (NB + 1);
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_src = 8'h00;
    logic [15:0] mem_address;
    logic        mem_re, mem_we;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;
    logic        busy, cpu_lock, done;

    oam_dma_engine #(.CYCLES_PER_BYTE(CPB), .OAM_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .dma_start(dma_start), .dma_src(dma_src),
        .mem_address(mem_address), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_lock(cpu_lock), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_src [0:NB-1];
    int          checks = 0;
    int          errors = 0;
    int          nread, nwrite, hi_acc, ndone;
    logic [15:0] first_raddr, last_raddr;

    function automatic logic [7:0] remap(input logic [7:0] s);
        return (s >= 8'hE0) ? 8'(s - 8'h20) : s;
    endfunction

    task automatic snap(input logic [7:0] s);
        for (int i = 0; i < NB; i++) exp_src[i] = mem[{s, 8'(i)}];
    endtask

    task automatic fill_oam_random();
        for (int i = 0; i < NB; i++) mem[{8'hFE, 8'(i)}] = 8'($urandom);
    endtask

    // Drives one copy (optionally a restart at r_at or a reset at rst_at,
    // both in cycles counted from the first start strobe) and checks every
    // clock against the expected schedule.
    task automatic run_copy(input logic [7:0] src, input int r_at,
                            input logic [7:0] r_src, input int rst_at);
        int          last_start;
        logic [7:0]  cur;
        logic        killed, pend, eb, ed, el;
        logic [15:0] paddr;
        killed = 0; pend = 0; last_start = 0; paddr = 16'h0;
        cur = remap(src); snap(cur);
        nread = 0; nwrite = 0; hi_acc = 0; ndone = 0;
        first_raddr = 16'hFFFF; last_raddr = 16'hFFFF;
        @(posedge clk); #1;
        dma_start = 1'b1; dma_src = src;
        for (int c = 1; c <= LIMIT; c++) begin
            @(posedge clk); #1;
            dma_start = (c == r_at);
            if (c == r_at) dma_src = r_src;
            rst = (c == rst_at);
            // Only the clock after a read carries real data.
            mem_rdata = pend ? mem[paddr] : 8'($urandom);
            @(negedge clk);
            eb = !killed && (c <= last_start + LAT);
            ed = !killed && (c == last_start + LAT + 1);
`ifdef OAM_DMA_CPU_LOCK_EN
            el = eb;
`else
            el = 1'b0;
`endif
            checks++;
            if (busy !== eb) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, eb); end
            checks++;
            if (done !== ed) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", c, done, ed); end
            checks++;
            if (cpu_lock !== el) begin errors++; $display("FAIL cpu_lock cyc=%0d got=%b exp=%b", c, cpu_lock, el); end
            checks++;
            if (mem_re === 1'b1 && mem_we === 1'b1) begin errors++; $display("FAIL re_we_both cyc=%0d", c); end
            if (!eb) begin
                checks++;
                if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL idle_bus cyc=%0d re=%b we=%b exp=0", c, mem_re, mem_we);
                end
            end
            if (done === 1'b1) ndone++;
            if (mem_re === 1'b1) begin
                if (mem_address >= 16'hE000) hi_acc++;
                if (first_raddr == 16'hFFFF) first_raddr = mem_address;
                last_raddr = mem_address;
                checks++;
                if (nread >= NB || mem_address !== {cur, 8'(nread)} ||
                    c != last_start + CPB * (nread + 1) + 1) begin
                    errors++;
                    $display("FAIL read cyc=%0d n=%0d got_addr=%h exp_addr=%h exp_cyc=%0d",
                             c, nread, mem_address, {cur, 8'(nread)}, last_start + CPB * (nread + 1) + 1);
                end
                nread++;
            end else if (mem_we === 1'b1) begin
                checks++;
                if (nwrite >= NB || mem_address !== {8'hFE, 8'(nwrite)} ||
                    mem_wdata !== exp_src[nwrite % NB] ||
                    c != last_start + CPB * (nwrite + 1) + 3) begin
                    errors++;
                    $display("FAIL write cyc=%0d n=%0d got=%h/%h exp=%h/%h exp_cyc=%0d", c, nwrite,
                             mem_address, mem_wdata, {8'hFE, 8'(nwrite)}, exp_src[nwrite % NB],
                             last_start + CPB * (nwrite + 1) + 3);
                end
                mem[mem_address] = mem_wdata;
                nwrite++;
            end else begin
                checks++;
                if (mem_address !== 16'h0000) begin
                    errors++; $display("FAIL addr_idle cyc=%0d got=%h exp=0000", c, mem_address);
                end
            end
            pend  = (mem_re === 1'b1);
            paddr = mem_address;
            if (c == r_at) begin
                last_start = c; cur = remap(r_src); snap(cur);
                nread = 0; nwrite = 0; ndone = 0;
            end
            if (c == rst_at) killed = 1;
            if ((!killed && c == last_start + LAT + 3) || (killed && c == rst_at + 3)) break;
            if (c == LIMIT) begin errors++; $display("FAIL timeout cyc=%0d", c); end
        end
        @(posedge clk); #1;
        dma_start = 1'b0; rst = 1'b0;
    endtask

    task automatic check_full_copy(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NB; i++) if (mem[{8'hFE, 8'(i)}] !== exp_src[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_oam bytes_wrong=%0d exp=0", tag, bad); end
        checks++;
        if (nread != NB || nwrite != NB) begin
            errors++; $display("FAIL %s_counts reads=%0d writes=%0d exp=%0d", tag, nread, nwrite, NB);
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL %s_done_count got=%0d exp=1", tag, ndone); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, cpu_lock, mem_re, mem_we} !== 5'b0 || mem_address !== 16'h0 || mem_wdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b lock=%b re=%b we=%b addr=%h wd=%h exp=all0",
                     busy, done, cpu_lock, mem_re, mem_we, mem_address, mem_wdata);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic_copy();
        for (int i = 0; i < NB; i++) mem[{8'hC1, 8'(i)}] = 8'(i) ^ 8'h5A;
        fill_oam_random();
        run_copy(8'hC1, -1, 8'h00, -1);
        check_full_copy("basic");
    endtask

    task automatic test_echo_remap();
        fill_oam_random();
        run_copy(8'hF0, -1, 8'h00, -1);
        check_full_copy("echo");
        checks++;
        if (first_raddr !== 16'hD000 || last_raddr !== 16'hD09F || hi_acc != 0) begin
            errors++;
            $display("FAIL echo_addr first=%h last=%h high=%0d exp=D000/D09F/0", first_raddr, last_raddr, hi_acc);
        end
    endtask

    task automatic test_restart();
        fill_oam_random();
        run_copy(8'hC1, 100, 8'hC2, -1);
        check_full_copy("restart");
    endtask

    task automatic test_restart_last_phase();
        fill_oam_random();
        run_copy(8'h80, LAT, 8'h43, -1);
        check_full_copy("restart_last");
    endtask

    task automatic test_mid_reset();
        fill_oam_random();
        run_copy(8'hC3, -1, 8'h00, 300);
        checks++;
        if (nwrite >= NB || nwrite == 0) begin
            errors++; $display("FAIL midrst_partial writes=%0d exp=1..%0d", nwrite, NB - 1);
        end
        fill_oam_random();
        run_copy(8'hC4, -1, 8'h00, -1);
        check_full_copy("after_rst");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            fill_oam_random();
            run_copy(8'($urandom_range(0, 255)), -1, 8'h00, -1);
            check_full_copy("random");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic_copy();
        test_echo_remap();
        test_restart();
        test_restart_last_phase();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
